nibble_fifo: RTL and testbench

NIBBLE_FIFO -- requirements
Module: nibble_fifo

---
 rtl/nibble_fifo_if.sv | 42 ++++
 rtl/nibble_fifo.sv | 99 +++++++++
 tb/tb_nibble_fifo.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/nibble_fifo_if.sv
// Handshake bundle between an upstream producer, the nibble FIFO and a
// downstream consumer. The master side is whoever drives the FIFO (the
// producer/consumer pair or a testbench); the slave side is the FIFO itself.
interface nibble_fifo_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             overflow;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count,
    output overflow
  );

endinterface

// File: rtl/nibble_fifo.sv
// Small first-word-fall-through FIFO for the 4-bit latch data path.
// Storage is a circular buffer addressed by read/write pointers; an explicit
// occupancy counter drives full/empty so that all handshake outputs come from
// registered state only. A sticky overflow flag records any word offered
// while the buffer was full.
module nibble_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  nibble_fifo_if.slave       bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic inReady;
  logic outValid;
  logic push;
  logic pop;

  // Full/empty come straight from the registered count; no bypass from out_ready
  always_comb begin
    inReady  = (count_q != FULL_COUNT);
    outValid = (count_q != '0);
    push     = bus.in_valid & inReady;
    pop      = outValid & bus.out_ready;
  end

  // Drive the interface; the head word is masked to zero whenever the queue is empty
  always_comb begin
    bus.in_ready  = inReady;
    bus.out_valid = outValid;
    bus.out_data  = outValid ? mem_q[rdPtr_q] : '0;
    bus.count     = count_q;
    bus.overflow  = overflow_q;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag; clr wins over any transfer
  always_comb begin
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      rdPtr_d    = '0;
      wrPtr_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.in_valid && !inReady) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control state with asynchronous reset back to an empty, non-overflowed queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array is left unreset; stale entries are hidden by the out_valid mask
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_q[wrPtr_q] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_nibble_fifo.sv
// Directed testbench for nibble_fifo: fill, overflow, drain, steady-state
// streaming with pointer wrap, push into an empty queue, and flushing by both
// asynchronous reset and synchronous clr.
module tb_nibble_fifo;

  logic clk;
  logic reset;
  logic clr;

  int errorCount;
  int checkCount;

  nibble_fifo_if #(.WIDTH(4), .DEPTH(4)) bus ();

  nibble_fifo #(.WIDTH(4), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .bus   (bus)
  );

  // Free-running 10 time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expectation and log any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive all FIFO inputs for the next edge
  task automatic applyStimulus(input logic inValid, input logic [3:0] inData, input logic outReady, input logic doClr);
    bus.in_valid  = inValid;
    bus.in_data   = inData;
    bus.out_ready = outReady;
    clr           = doClr;
  endtask

  // Advance past one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fillVals [4];
  logic [3:0] model [$];
  logic [3:0] v;

  // Main directed sequence
  initial begin
    errorCount = 0;
    checkCount = 0;
    fillVals[0] = 4'h3;
    fillVals[1] = 4'h5;
    fillVals[2] = 4'h9;
    fillVals[3] = 4'hC;

    reset = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    #2;
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'h0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Fill to full with out_ready low
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fillVals[i], 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("fill_count_%0d", i), 32'(bus.count), 32'(i + 1));
      checkOutput($sformatf("fill_head_%0d", i), 32'(bus.out_data), 32'h3);
    end
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("full_out_valid", 32'(bus.out_valid), 32'd1);

    // Offer a word while full
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
    tick();
    checkOutput("ovf_flag", 32'(bus.overflow), 32'd1);
    checkOutput("ovf_count", 32'(bus.count), 32'd4);
    checkOutput("ovf_head", 32'(bus.out_data), 32'h3);

    // Drain in order
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_data_%0d", i), 32'(bus.out_data), 32'(fillVals[i]));
      tick();
    end
    checkOutput("drain_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("drain_out_data", 32'(bus.out_data), 32'h0);
    checkOutput("drain_count", 32'(bus.count), 32'd0);
    checkOutput("drain_ovf_sticky", 32'(bus.overflow), 32'd1);

    // Pop request while empty does nothing
    tick();
    checkOutput("empty_pop_count", 32'(bus.count), 32'd0);
    checkOutput("empty_pop_in_ready", 32'(bus.in_ready), 32'd1);

    // Synchronous clear drops the sticky flag
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    tick();
    checkOutput("clr_ovf", 32'(bus.overflow), 32'd0);

    // Preload two words, then stream push+pop together
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
    tick();
    model.push_back(4'h1);
    model.push_back(4'h2);
    checkOutput("stream_pre_count", 32'(bus.count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      v = 4'(i + 4);
      checkOutput($sformatf("stream_data_%0d", i), 32'(bus.out_data), 32'(model[0]));
      applyStimulus(1'b1, v, 1'b1, 1'b0);
      tick();
      model.push_back(v);
      void'(model.pop_front());
      checkOutput($sformatf("stream_count_%0d", i), 32'(bus.count), 32'd2);
    end
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("stream_tail_%0d", i), 32'(bus.out_data), 32'(model[0]));
      void'(model.pop_front());
      tick();
    end
    checkOutput("stream_empty", 32'(bus.out_valid), 32'd0);

    // Push into empty with out_ready high: one-cycle latency, then popped
    applyStimulus(1'b1, 4'hA, 1'b1, 1'b0);
    checkOutput("lat_pre_valid", 32'(bus.out_valid), 32'd0);
    tick();
    checkOutput("lat_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("lat_data", 32'(bus.out_data), 32'hA);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("lat_popped_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("lat_popped_count", 32'(bus.count), 32'd0);

    // Build count=3 with overflow set, then reset asynchronously between edges
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fillVals[i], 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("pre_areset_count", 32'(bus.count), 32'd3);
    checkOutput("pre_areset_ovf", 32'(bus.overflow), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("areset_count", 32'(bus.count), 32'd0);
    checkOutput("areset_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("areset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("areset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("areset_out_data", 32'(bus.out_data), 32'h0);
    #1;
    reset = 1'b0;

    // First edge after reset behaves as an empty queue
    applyStimulus(1'b1, 4'h7, 1'b1, 1'b0);
    tick();
    checkOutput("post_reset_count", 32'(bus.count), 32'd1);
    checkOutput("post_reset_data", 32'(bus.out_data), 32'h7);

    // Same scenario flushed by clr, with a push and pop on the clr edge
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b1, fillVals[i], 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("pre_clr_count", 32'(bus.count), 32'd3);
    checkOutput("pre_clr_ovf", 32'(bus.overflow), 32'd1);
    applyStimulus(1'b1, 4'h5, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("clr_count", 32'(bus.count), 32'd0);
    checkOutput("clr_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("clr_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("clr_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("clr_out_data", 32'(bus.out_data), 32'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
